// File: rtl/sa_drain_ctrl.sv
// sa_drain_ctrl: PE-array drain FSM feeding a row FIFO stream; define SA_DRAIN_RELU_EN to clamp negative lanes to 0 at FIFO write.
module sa_drain_ctrl #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   load_sum,
  input  logic [N*32-1:0]        col_sum_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*32-1:0]        out_data,
  output logic [$clog2(M)-1:0]   out_row,
  output logic                   out_last
);
  localparam int RW = $clog2(M);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = N * 32 + RW + 1;
  typedef enum logic [1:0] {IDLE, WAIT_SPACE, DRAIN} state_t;
  state_t          state_q;
  logic [RW-1:0]   cnt_q;
  logic            busy_q, done_q, load_q;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   fcnt_q;
  logic [N*32-1:0] wdata;
  logic            space, push, pop;
  assign space     = fcnt_q <= CW'(FIFO_DEPTH - M);
  assign push      = load_q;
  assign pop       = out_valid && out_ready;
  assign busy      = busy_q;
  assign done      = done_q;
  assign load_sum  = load_q;
  assign out_valid = fcnt_q != '0;
  assign {out_last, out_row, out_data} = out_valid ? mem[rd_q] : '0;
`ifdef SA_DRAIN_RELU_EN
  always_comb begin
    wdata = col_sum_in;
    for (int i = 0; i < N; i++)
      wdata[i*32+:32] = col_sum_in[i*32+31] ? 32'd0 : col_sum_in[i*32+:32];
  end
`else
  assign wdata = col_sum_in;
`endif
  // Space is reserved up front so pushes during DRAIN never need to stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          busy_q  <= 1'b1;
          load_q  <= space;
          state_q <= space ? DRAIN : WAIT_SPACE;
        end
        WAIT_SPACE: if (space) begin
          load_q  <= 1'b1;
          state_q <= DRAIN;
        end
        DRAIN: if (cnt_q == RW'(M - 1)) begin
          cnt_q   <= '0;
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= {cnt_q == RW'(M - 1), RW'(M - 1) - cnt_q, wdata};
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_q + 1'b1;
      if (pop) rd_q <= rd_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_q + 1'b1;
      fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_sa_drain_ctrl.sv
// tb_sa_drain_ctrl: directed tests for the drain controller and its row FIFO.
module tb_sa_drain_ctrl;
  localparam int M = 4;
  localparam int N = 4;
  localparam int D = 8;
  logic            clk = 1'b0;
  logic            reset, start, out_ready;
  logic [N*32-1:0] col_sum_in;
  logic            busy, done, load_sum, out_valid, out_last;
  logic [N*32-1:0] out_data;
  logic [1:0]      out_row;
  int              total = 0;
  int              bad = 0;
  logic [N*32-1:0] q_data [$];
  int              q_row [$];

  sa_drain_ctrl #(.M(M), .N(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .load_sum(load_sum), .col_sum_in(col_sum_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [N*32-1:0] row_val(int base, int r);
    logic [N*32-1:0] v;
    for (int c = 0; c < N; c++) v[c*32+:32] = 32'(base + r * 10 + c);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; col_sum_in = '0;
    tick; tick;
    total++;
    if ({busy, done, load_sum, out_valid, out_last} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, load_sum, out_valid, out_last});
    end
    total++;
    if ({out_row, out_data} !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h exp=0", out_row, out_data);
    end
    reset = 1'b0;
    tick;
    total++;
    if ({busy, load_sum, out_valid} !== 3'b0) begin
      bad++; $display("FAIL reset_idle got=%b exp=000", {busy, load_sum, out_valid});
    end
  endtask

  task automatic test_basic;
    int nload = 0;
    out_ready = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < M; k++) begin
      col_sum_in = row_val(0, M - 1 - k);
      if (load_sum) nload++;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy k=%0d got=%b exp=1", k, busy); end
      total++;
      if (k == 0) begin
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid0 got=%b exp=0", out_valid); end
      end else if ({out_valid, out_last, out_row, out_data} !== {1'b1, 1'b0, 2'(M - k), row_val(0, M - k)}) begin
        bad++; $display("FAIL basic_row k=%0d got=%b/%b/%0d/%h exp=1/0/%0d/%h",
                        k, out_valid, out_last, out_row, out_data, M - k, row_val(0, M - k));
      end
      tick;
    end
    total++;
    if ({done, busy, load_sum} !== 3'b100) begin
      bad++; $display("FAIL basic_done got=%b exp=100", {done, busy, load_sum});
    end
    total++;
    if ({out_valid, out_last, out_row, out_data} !== {1'b1, 1'b1, 2'd0, row_val(0, 0)}) begin
      bad++; $display("FAIL basic_last got=%b/%b/%0d/%h exp=1/1/0/%h", out_valid, out_last, out_row, out_data, row_val(0, 0));
    end
    total++;
    if (nload != M) begin bad++; $display("FAIL basic_load_cycles got=%0d exp=%0d", nload, M); end
    tick;
    total++;
    if ({done, out_valid} !== 2'b00) begin bad++; $display("FAIL basic_after got=%b exp=00", {done, out_valid}); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < M; k++) begin
      col_sum_in = row_val(100, M - 1 - k);
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, out_last, out_row, out_data} !== {1'b1, 1'b0, 2'd3, row_val(100, 3)}) begin
        bad++; $display("FAIL bp_stall i=%0d got=%b/%0d/%h exp=1/3/%h", i, out_valid, out_row, out_data, row_val(100, 3));
      end
      tick;
    end
    out_ready = 1'b1;
    for (int i = 0; i < M; i++) begin
      total++;
      if ({out_valid, out_last, out_row, out_data} !== {1'b1, i == M - 1, 2'(M - 1 - i), row_val(100, M - 1 - i)}) begin
        bad++; $display("FAIL bp_release i=%0d got=%b/%b/%0d/%h exp row %0d", i, out_valid, out_last, out_row, out_data, M - 1 - i);
      end
      tick;
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_space_wait;
    out_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; tick; start = 1'b0;
      for (int k = 0; k < M; k++) begin
        col_sum_in = row_val(200 + 100 * t, M - 1 - k);
        tick;
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({out_row, out_data} !== {2'(3 - i), row_val(200, 3 - i)}) begin
        bad++; $display("FAIL sw_prepop i=%0d got=%0d/%h exp=%0d", i, out_row, out_data, 3 - i);
      end
      tick;
    end
    out_ready = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({busy, load_sum} !== 2'b10) begin bad++; $display("FAIL sw_wait i=%0d got=%b exp=10", i, {busy, load_sum}); end
      tick;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({out_last, out_row, out_data} !== {i == 1, 2'(1 - i), row_val(200, 1 - i)}) begin
        bad++; $display("FAIL sw_pop i=%0d got=%b/%0d/%h exp row %0d", i, out_last, out_row, out_data, 1 - i);
      end
      if (load_sum !== 1'b0) begin bad++; $display("FAIL sw_pop_load i=%0d got=%b exp=0", i, load_sum); end
      tick;
    end
    out_ready = 1'b0;
    total++;
    if ({busy, load_sum} !== 2'b10) begin bad++; $display("FAIL sw_space_seen got=%b exp=10", {busy, load_sum}); end
    tick;
    for (int k = 0; k < M; k++) begin
      col_sum_in = row_val(400, M - 1 - k);
      total++;
      if (load_sum !== 1'b1) begin bad++; $display("FAIL sw_drain k=%0d got=%b exp=1", k, load_sum); end
      tick;
    end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL sw_done got=%b exp=1", done); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({out_valid, out_row, out_data} !== {1'b1, 2'(3 - i % 4), row_val(i < 4 ? 300 : 400, 3 - i % 4)}) begin
        bad++; $display("FAIL sw_flush i=%0d got=%b/%0d/%h", i, out_valid, out_row, out_data);
      end
      tick;
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL sw_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int nload = 0;
    int npop = 0;
    logic [N*32-1:0] ed;
    int er;
    out_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      int t = i / 5;
      int p = i % 5;
      start = (t < 3) && (p == 0 || p == 2);
      if (t < 3 && p >= 1) begin
        col_sum_in = row_val(500 + 100 * t, 4 - p);
        q_data.push_back(row_val(500 + 100 * t, 4 - p));
        q_row.push_back(4 - p);
      end
      total++;
      if (load_sum !== (t < 3 && p >= 1)) begin
        bad++; $display("FAIL b2b_load i=%0d got=%b exp=%b", i, load_sum, t < 3 && p >= 1);
      end
      if (load_sum) nload++;
      if (out_valid) begin
        total++;
        if (q_row.size() == 0) begin
          bad++; $display("FAIL b2b_extra_row i=%0d got row %0d exp none", i, out_row);
        end else begin
          ed = q_data.pop_front();
          er = q_row.pop_front();
          npop++;
          if ({out_last, out_row, out_data} !== {er == 0, 2'(er), ed}) begin
            bad++; $display("FAIL b2b_row i=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, out_last, out_row, out_data, er == 0, er, ed);
          end
        end
      end
      tick;
    end
    start = 1'b0;
    total++;
    if (nload != 12) begin bad++; $display("FAIL b2b_load_cycles got=%0d exp=12", nload); end
    total++;
    if (npop != 12) begin bad++; $display("FAIL b2b_rows got=%0d exp=12", npop); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    col_sum_in = row_val(800, 3); tick;
    col_sum_in = row_val(800, 2); tick;
    total++;
    if (load_sum !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b exp=1", load_sum); end
    reset = 1'b1; tick; reset = 1'b0;
    total++;
    if ({load_sum, out_valid, busy, done} !== 4'b0) begin
      bad++; $display("FAIL rm_after got=%b exp=0000", {load_sum, out_valid, busy, done});
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({load_sum, out_valid, busy, done} !== 4'b0) begin
        bad++; $display("FAIL rm_idle i=%0d got=%b exp=0000", i, {load_sum, out_valid, busy, done});
      end
    end
  endtask

  task automatic test_relu;
    logic [N*32-1:0] vin, vexp;
    vin = {32'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFB};
`ifdef SA_DRAIN_RELU_EN
    vexp = {32'd7, 32'd0, 32'h7FFF_FFFF, 32'd0};
`else
    vexp = vin;
`endif
    out_ready = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < M; k++) begin
      col_sum_in = vin;
      tick;
    end
    out_ready = 1'b1;
    for (int i = 0; i < M; i++) begin
      total++;
      if ({out_valid, out_row, out_data} !== {1'b1, 2'(3 - i), vexp}) begin
        bad++; $display("FAIL relu i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, out_valid, out_row, out_data, 3 - i, vexp);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_space_wait;
    test_back_to_back;
    test_reset_mid;
    test_relu;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sa_drain_ctrl.md
# sa_drain_ctrl

Drain controller and output buffer directly downstream of the tensor PE array. After a tile's accumulation completes, it asserts `load_sum` to the whole array for M cycles, shifting each column's int32 accumulators down the `sum_in`/`sum_out` chain. Each cycle it captures the bottom-row `sum_out` of all N columns into a row FIFO. It then emits the captured rows on a valid/ready stream to the requantization/writeback stage.

## Interface
Parameters:
- `M`, 4: PE array rows, i.e. rows drained per tile; at least 2.
- `N`, 4: PE array columns, i.e. int32 lanes per output row.
- `FIFO_DEPTH`, 8: row FIFO depth in entries; must be at least M.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request to drain the array; sampled only in IDLE.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse after the last row has been captured.
- `load_sum`, output, 1: broadcast to every PE `load_sum` input.
- `col_sum_in`, input, N×int32_t: bottom-row PE `sum_out` values; element 0 is the left-most column.
- `out_valid`, output, 1: FIFO head is valid.
- `out_ready`, input, 1: consumer accepts the head.
- `out_data`, output, N×int32_t: captured row.
- `out_row`, output, $clog2(M): array row index of `out_data`.
- `out_last`, output, 1: marks row 0, the final row of the tile.

Top-row PE `sum_in` is tied to 0 at the array level, so drained accumulators are left cleared.

## Operation
- FSM states are IDLE, WAIT_SPACE and DRAIN.
- **IDLE:**
  - On `start`, go to DRAIN if free FIFO entries ≥ M; otherwise go to WAIT_SPACE.
  - `start` in any other state is ignored. It is not queued.
- **WAIT_SPACE:** move to DRAIN in the first cycle where free entries ≥ M.
- **DRAIN:**
  - Drive `load_sum`=1 and advance counter `cnt` from 0 to M-1.
  - Every cycle, push {`col_sum_in`, row=M-1-`cnt`, last=(`cnt`==M-1)} into the FIFO.
  - After `cnt`==M-1, go to IDLE and pulse `done` in that next cycle.
- Rows are emitted bottom first: M-1, M-2, …, 0.
- A push is never blocked: space is reserved before entering DRAIN. A pop during DRAIN frees space but does not alter the sequence.
- The FIFO is a circular buffer with read and write pointers wrapping at FIFO_DEPTH and a count of width $clog2(FIFO_DEPTH+1). Simultaneous push and pop leave the count unchanged.
- Pop occurs on `out_valid && out_ready`. While `out_valid`=1 and `out_ready`=0, `out_data`, `out_row` and `out_last` hold stable.
- No arithmetic is applied to the data; values pass through at full 32-bit width, except as described under Configuration.

## Timing
- Reset values:
  - State IDLE, `cnt`=0, FIFO empty.
  - `busy`, `done`, `load_sum` and `out_valid` are 0.
  - `out_data`, `out_row` and `out_last` are 0.
- With space available, `start` at edge T gives `load_sum`=1 for cycles T+1 … T+M.
- The value on `col_sum_in` during cycle T+1+k is captured as row M-1-k.
- The cycle-T+1 value is the bottom-row accumulator before any shift.
- `done`=1 in cycle T+M+1, with `busy`=0 in that same cycle.
- `load_sum` is decoded only from the registered state, with no combinational path from `start`.
- `out_valid` rises in the cycle after the first push: T+2 when the FIFO was empty. Read latency is one cycle after the write edge.
- If `out_ready` is held at 1, one row is emitted per cycle, and the last row appears in cycle T+M+1.
- Reset during DRAIN:
  - `load_sum`=0 and IDLE from the next cycle.
  - The FIFO is flushed and `done` is not pulsed.
  - The PE array is reset by the same signal.

## Configuration
- Macro `SA_DRAIN_RELU_EN`:
  - **Defined:** each lane is clamped at FIFO write: a negative int32 becomes 0 and a non-negative value is unchanged. There is no added latency.
  - **Undefined:** lanes pass through unmodified.

## Test plan
- **Basic drain:** M=N=4, `col_sum_in` driven as {r*10+c} for row r, `out_ready`=1.
  - Required: `load_sum` high for exactly 4 cycles.
  - Required: outputs row 3, 2, 1, 0 with matching data, `out_last` only on row 0, and `done` in cycle T+5.
- **Backpressure:** `out_ready`=0 during the drain, then released.
  - Required: all 4 rows are retained, and the head is stable while stalled.
  - Required: after release, the rows are emitted in order at 1 per cycle.
- **Space wait:** FIFO_DEPTH=8 holding 6 unread rows, then `start`.
  - Required: the block stays in WAIT_SPACE with `load_sum`=0 and `busy`=1.
  - Required: after 2 pops, DRAIN begins on the next cycle.
- **Ignored start and wrap:** pulse `start` during DRAIN, then run 3 back-to-back tiles.
  - Required: no extra drain occurs.
  - Required: pointer wrap preserves order, with 12 rows emitted correctly.
- **Reset mid-drain:** assert `reset` with `cnt`=2.
  - Required: the next cycle has `load_sum`=0, `out_valid`=0 and `busy`=0, and no `done` pulse.
- **ReLU:** with `SA_DRAIN_RELU_EN` defined, inputs -5, 0x7FFFFFFF, 0x80000000 and 7.
  - Required: outputs are 0, 0x7FFFFFFF, 0 and 7.
  - Required: with the macro undefined, the same inputs produce identical outputs.
